fan_pwm_gen: RTL and testbench
==============================

# fan_pwm_gen

Fan PWM generator directly downstream of the PID controller. It converts the signed 9-bit PID output into an unsigned duty cycle and drives the fan PWM pin. It also produces the once-per-period enable pulse that starts each PID computation, so the control loop runs in lockstep with the PWM period. It includes period-synchronous duty updates, a minimum-duty floor, and a full-power kick-start when the fan restarts from 0 %.

## Interface
Parameters:
- ADC_BITWIDTH, 8: duty and PWM counter width; PID input is ADC_BITWIDTH+1 bits signed.
- PRESCALE, 4: clk_i cycles per PWM tick; legal range ≥1.
- KICK_PERIODS, 16: number of full-duty PWM periods applied on a 0→nonzero restart; 0 disables kick-start.
- MIN_DUTY, 0: floor applied to any nonzero target duty.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  block enable; low forces the idle state.
- pid_val_i  in  ADC_BITWIDTH+1  signed PID output (out_Val_o of the controller).
- pwm_o  out  1  registered PWM to the fan.
- pid_en_o  out  1  one-cycle pulse; drives the controller's clk_en_PID_i.
- duty_o  out  ADC_BITWIDTH  active effective duty (after kick override).
- kick_o  out  1  high while kick-start is active.

## Operation
- Target duty T (combinational from pid_val_i):
  - pid_val_i < 0 → 0.
  - Otherwise the low ADC_BITWIDTH bits; a nonnegative 9-bit value is at most 255.
  - If 0 < T < MIN_DUTY, then T = MIN_DUTY.
- Prescaler psc counts 0..PRESCALE-1. tick = (psc == PRESCALE-1).
- Period counter cnt counts 0..CNT_MAX, where CNT_MAX = 2^ADC_BITWIDTH-2. It advances on tick and wraps from CNT_MAX to 0.
- Period start event PS:
  - (tick && cnt == CNT_MAX), or
  - the first enabled cycle after enable_i was low or after reset. In that case psc and cnt start from 0.
- On PS:
  - Sample T into the active duty register D.
  - Pulse pid_en_o for exactly one cycle.
  - Kick logic:
    - D_old == 0 and T != 0 and KICK_PERIODS > 0 → load kick counter K = KICK_PERIODS.
    - T == 0 → K = 0 (abort any kick in progress).
    - Otherwise, if K > 0 → K = K-1.
- Effective duty E = (K > 0) ? 2^ADC_BITWIDTH-1 : D. duty_o = E and kick_o = (K > 0); both are registered and update on PS.
- PWM compare: pwm_o <= enable_i && (cnt < E).
  - E = 255 gives constant high, because cnt ≤ 254.
  - E = 0 gives constant low.
  - High time is E ticks per period of 2^ADC_BITWIDTH-1 ticks.
- pid_val_i changes between PS events are ignored; there are no mid-period duty glitches.
- enable_i low:
  - psc, cnt, K and D are cleared.
  - pwm_o, pid_en_o, duty_o and kick_o are 0 from the next edge.
- Restart after enable counts as a 0→T transition, so kick applies.

## Timing
- Reset (rst_i high at an edge): pwm_o=0, pid_en_o=0, duty_o=0, kick_o=0, psc=0, cnt=0, K=0, D=0. Reset mid-period aborts immediately; no partial pulse completes.
- First PS occurs on the first edge with rst_i low and enable_i high. pid_en_o is high in the following cycle.
- PWM period = PRESCALE·(2^ADC_BITWIDTH-1) clocks; 1020 with defaults.
- pid_en_o spacing is exactly one PWM period in steady state.
- Latency from PS to the new duty visible on pwm_o: 1 clock, because pwm_o is registered.
- The controller's result is consumed at the next PS, so duty lags the PID update by one period.
- Simultaneous rst_i and enable_i: reset wins.
- Kick duration is exactly KICK_PERIODS full periods of constant-high pwm_o. The first PS with K == 1 decrements it to 0 and D takes effect in that period.

## Test plan
- Defaults, enable_i=1, pid_val_i=128:
  - First period kicks (duty_o=255, kick_o=1) for 16 periods.
  - Thereafter pwm_o is high for 512 of every 1020 clocks, duty_o=128.
  - pid_en_o pulses every 1020 clocks.
- pid_val_i=-5:
  - duty_o=0, pwm_o constant 0, kick_o=0.
  - pid_en_o still pulses every 1020 clocks.
- Running at duty 100, pid_val_i changed to 200 at mid-period:
  - Current period keeps 400 high clocks.
  - Next period has 800 high clocks; no kick.
- Kick abort: from 0, pid_val_i=40, then pid_val_i=0 at the 3rd PS:
  - kick_o drops at that PS.
  - duty_o=0 and pwm_o low from the following clock.
- MIN_DUTY=20, pid_val_i=5 (after kick expiry):
  - duty_o=20, 80 high clocks per period.
  - pid_val_i=0 gives duty_o=0, not 20.
- rst_i asserted mid-high-pulse:
  - All outputs 0 the next cycle.
  - After release, the first pid_en_o arrives on the first enabled clock and kick restarts.
- enable_i toggled low for 3 cycles behaves the same way.

Source files
------------

// File: rtl/fan_pwm_gen.sv
// Fan PWM generator: PID output -> duty cycle, PWM pin and PID enable pulse.
// Duty updates only at period start; includes min-duty floor and kick-start.
module fan_pwm_gen #(
    parameter int ADC_BITWIDTH = 8,
    parameter int PRESCALE     = 4,
    parameter int KICK_PERIODS = 16,
    parameter int MIN_DUTY     = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [ADC_BITWIDTH:0]   pid_val_i,
    output logic                    pwm_o,
    output logic                    pid_en_o,
    output logic [ADC_BITWIDTH-1:0] duty_o,
    output logic                    kick_o
);

    localparam int N   = ADC_BITWIDTH;
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int KW  = (KICK_PERIODS > 0) ? $clog2(KICK_PERIODS + 1) : 1;

    localparam logic [PSW-1:0] PSC_MAX   = PSW'(PRESCALE - 1);
    localparam logic [N-1:0]   CNT_MAX   = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0]   DUTY_FULL = {N{1'b1}};
    localparam logic [KW-1:0]  KICK_LD   = KW'(KICK_PERIODS);
    localparam bit             KICK_EN   = (KICK_PERIODS > 0);

    // Registered state
    logic [PSW-1:0] psc_q, psc_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]  k_q, k_d;
    logic [N-1:0]   d_q, d_d;
    logic [N-1:0]   duty_q, duty_d;
    logic           kick_q, kick_d;
    logic           pwm_q, pwm_d;
    logic           pid_en_q, pid_en_d;
    logic           run_q, run_d;

    // Combinational helpers
    logic           neg;
    logic [N-1:0]   t_raw;
    logic [N-1:0]   t_floor;
    logic           tick;
    logic           ps;
    logic [KW-1:0]  k_ps;
    logic [N-1:0]   e_ps;

    // Negative PID output means "no drive"; otherwise take the magnitude bits.
    always_comb begin
        neg   = pid_val_i[N];
        t_raw = neg ? '0 : pid_val_i[N-1:0];
    end

    // Nonzero targets below the floor are raised to it; zero stays zero.
    if (MIN_DUTY > 0) begin : g_floor
        localparam logic [N-1:0] MIN_D = N'(MIN_DUTY);
        assign t_floor = ((t_raw != '0) && (t_raw < MIN_D)) ? MIN_D : t_raw;
    end else begin : g_nofloor
        assign t_floor = t_raw;
    end

    // Period start: end of the last tick of a period, or the first enabled cycle.
    always_comb begin
        tick = (psc_q == PSC_MAX);
        ps   = enable_i && (!run_q || (tick && (cnt_q == CNT_MAX)));
    end

    // Kick counter value to load at period start.
    always_comb begin
        k_ps = k_q;
        if (KICK_EN && (d_q == '0) && (t_floor != '0)) begin
            k_ps = KICK_LD;
        end else if (t_floor == '0) begin
            k_ps = '0;
        end else if (k_q != '0) begin
            k_ps = k_q - KW'(1);
        end
        e_ps = (k_ps != '0) ? DUTY_FULL : t_floor;
    end

    // Next-state logic for counters, duty registers and outputs.
    always_comb begin
        psc_d    = psc_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        d_d      = d_q;
        duty_d   = duty_q;
        kick_d   = kick_q;
        pid_en_d = 1'b0;
        run_d    = run_q;
        pwm_d    = 1'b0;
        if (!enable_i) begin
            psc_d  = '0;
            cnt_d  = '0;
            k_d    = '0;
            d_d    = '0;
            duty_d = '0;
            kick_d = 1'b0;
            run_d  = 1'b0;
        end else begin
            pwm_d = (cnt_q < duty_q);
            if (ps) begin
                psc_d    = '0;
                cnt_d    = '0;
                run_d    = 1'b1;
                pid_en_d = 1'b1;
                d_d      = t_floor;
                k_d      = k_ps;
                duty_d   = e_ps;
                kick_d   = (k_ps != '0);
            end else begin
                psc_d = tick ? '0 : psc_q + PSW'(1);
                if (tick) begin
                    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + N'(1);
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psc_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            d_q      <= '0;
            duty_q   <= '0;
            kick_q   <= 1'b0;
            pwm_q    <= 1'b0;
            pid_en_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            psc_q    <= psc_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            d_q      <= d_d;
            duty_q   <= duty_d;
            kick_q   <= kick_d;
            pwm_q    <= pwm_d;
            pid_en_q <= pid_en_d;
            run_q    <= run_d;
        end
    end

    assign pwm_o    = pwm_q;
    assign pid_en_o = pid_en_q;
    assign duty_o   = duty_q;
    assign kick_o   = kick_q;

endmodule

// File: tb/tb_fan_pwm_gen.sv
// Directed testbench for fan_pwm_gen: default instance plus a
// MIN_DUTY=20 / short-kick instance.
module tb_fan_pwm_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       en2 = 1'b0;
    logic [8:0] pid  = '0;
    logic [8:0] pid2 = '0;

    logic       pwm1, pen1, kick1;
    logic [7:0] duty1;
    logic       pwm2, pen2, kick2;
    logic [7:0] duty2;

    logic       sel = 1'b0;
    logic       pwm_s, pen_s;

    int checks = 0;
    int errors = 0;
    int high, pos;

    always #5 clk = ~clk;

    fan_pwm_gen dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .pid_val_i(pid),
        .pwm_o(pwm1), .pid_en_o(pen1), .duty_o(duty1), .kick_o(kick1)
    );

    fan_pwm_gen #(
        .ADC_BITWIDTH(8), .PRESCALE(4), .KICK_PERIODS(2), .MIN_DUTY(20)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .enable_i(en2), .pid_val_i(pid2),
        .pwm_o(pwm2), .pid_en_o(pen2), .duty_o(duty2), .kick_o(kick2)
    );

    assign pwm_s = sel ? pwm2 : pwm1;
    assign pen_s = sel ? pen2 : pen1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Samples 1020 clocks after a pid_en pulse; counts pwm high clocks
    // and records where the next pid_en pulse lands.
    task automatic measure(input int chg_at, input int chg_val,
                           output int hi, output int pp);
        hi = 0;
        pp = 0;
        for (int i = 1; i <= 1020; i++) begin
            if (i == chg_at) pid = 9'(chg_val);
            @(negedge clk);
            if (pwm_s) hi++;
            if (pen_s && pp == 0) pp = i;
        end
    endtask

    task automatic wait_pen(input string tag, input int max);
        int n;
        n = 0;
        while (!pen_s && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(pen_s), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm1), 0);
        check("rst_pen", int'(pen1), 0);
        check("rst_duty", int'(duty1), 0);
        check("rst_kick", int'(kick1), 0);

        // Enable at duty 128: immediate PS, 16 kicked periods
        rst = 1'b0;
        en  = 1'b1;
        pid = 9'd128;
        @(negedge clk);
        check("first_pen", int'(pen1), 1);
        check("first_duty", int'(duty1), 255);
        check("first_kick", int'(kick1), 1);
        measure(0, 0, high, pos);
        check("kick_high", high, 1020);
        check("kick_period", pos, 1020);
        for (int p = 2; p <= 15; p++) measure(0, 0, high, pos);
        check("kick16_kick", int'(kick1), 1);
        check("kick16_duty", int'(duty1), 255);
        measure(0, 0, high, pos);
        check("kick16_high", high, 1020);
        check("post_kick", int'(kick1), 0);
        check("post_duty", int'(duty1), 128);

        // Duty 128 period, then 100 with mid-period change to 200
        pid = 9'd100;
        measure(0, 0, high, pos);
        check("d128_high", high, 512);
        check("d128_period", pos, 1020);
        check("d100_duty", int'(duty1), 100);
        measure(510, 200, high, pos);
        check("d100_high", high, 400);
        check("d100_period", pos, 1020);
        check("d200_duty", int'(duty1), 200);
        check("d200_kick", int'(kick1), 0);

        // Negative PID output
        pid = 9'(-5);
        measure(0, 0, high, pos);
        check("d200_high", high, 800);
        check("neg_duty", int'(duty1), 0);
        check("neg_kick", int'(kick1), 0);
        pid = 9'd40;
        measure(0, 0, high, pos);
        check("neg_high", high, 0);
        check("neg_period", pos, 1020);

        // Kick abort: 40 sampled at PS1, 0 sampled at PS3
        check("abort_ps1_kick", int'(kick1), 1);
        measure(0, 0, high, pos);
        check("abort_ps2_kick", int'(kick1), 1);
        pid = 9'd0;
        measure(0, 0, high, pos);
        check("abort_kick", int'(kick1), 0);
        check("abort_duty", int'(duty1), 0);
        @(negedge clk);
        check("abort_pwm", int'(pwm1), 0);

        // Reset mid high pulse
        pid = 9'd128;
        wait_pen("rs_wait_pen", 1100);
        check("rs_kick", int'(kick1), 1);
        repeat (10) @(negedge clk);
        check("rs_pwm_high", int'(pwm1), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rs_pwm", int'(pwm1), 0);
        check("rs_pen", int'(pen1), 0);
        check("rs_duty", int'(duty1), 0);
        check("rs_kick0", int'(kick1), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rs_rel_pen", int'(pen1), 1);
        check("rs_rel_kick", int'(kick1), 1);
        check("rs_rel_duty", int'(duty1), 255);

        // Enable low for 3 cycles
        repeat (20) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_pwm", int'(pwm1), 0);
        check("en_duty", int'(duty1), 0);
        check("en_kick", int'(kick1), 0);
        check("en_pen", int'(pen1), 0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("en_rel_pen", int'(pen1), 1);
        check("en_rel_kick", int'(kick1), 1);
        measure(0, 0, high, pos);
        check("en_rel_high", high, 1020);
        check("en_rel_period", pos, 1020);

        // MIN_DUTY=20 instance, 2 kick periods
        en  = 1'b0;
        sel = 1'b1;
        en2 = 1'b1;
        pid2 = 9'd5;
        @(negedge clk);
        check("md_pen", int'(pen2), 1);
        check("md_kick", int'(kick2), 1);
        measure(0, 0, high, pos);
        check("md_kick_high", high, 1020);
        measure(0, 0, high, pos);
        check("md_duty", int'(duty2), 20);
        check("md_kick0", int'(kick2), 0);
        pid2 = 9'd0;
        measure(0, 0, high, pos);
        check("md_high", high, 80);
        check("md_period", pos, 1020);
        check("md_zero_duty", int'(duty2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
